// File: rtl/dat_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Supports bounded-length locked bursts and returns registered read data.
module dat_mem_arbiter #(
    parameter int LOCK_MAX = 16,
    parameter int AW       = 8,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req_a,
    input  logic          we_a,
    input  logic          lock_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,

    input  logic          req_b,
    input  logic          we_b,
    input  logic          lock_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    input  logic [DW-1:0] mem_dat_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK_A = 2'd1;
    localparam logic [1:0] ST_LOCK_B = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    logic [1:0]    r_arb_st;
    logic          r_last_gnt;
    logic [7:0]    r_lock_cnt;
    logic          r_rvalid_a;
    logic          r_rvalid_b;
    logic [DW-1:0] r_rdata_a;
    logic [DW-1:0] r_rdata_b;

    logic          w_gnt_a;
    logic          w_gnt_b;
    logic [1:0]    w_arb_st_nxt;
    logic          w_last_gnt_nxt;
    logic [7:0]    w_lock_cnt_nxt;
    logic          w_force;

    // Grants are gated by reset so nothing reaches the memory in the reset cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!reset) begin
            case (r_arb_st)
                ST_IDLE: begin
                    if (req_a && req_b) begin
                        w_gnt_a = (r_last_gnt == SEL_B);
                        w_gnt_b = (r_last_gnt == SEL_A);
                    end else begin
                        w_gnt_a = req_a;
                        w_gnt_b = req_b;
                    end
                end
                ST_LOCK_A: w_gnt_a = req_a;
                ST_LOCK_B: w_gnt_b = req_b;
                default: ;
            endcase
        end
    end

    assign w_force = (r_lock_cnt == LOCK_LIMIT);

    always_comb begin
        w_arb_st_nxt   = r_arb_st;
        w_lock_cnt_nxt = r_lock_cnt;
        w_last_gnt_nxt = r_last_gnt;
        if (w_gnt_a) begin
            w_last_gnt_nxt = SEL_A;
        end else if (w_gnt_b) begin
            w_last_gnt_nxt = SEL_B;
        end
        case (r_arb_st)
            ST_IDLE: begin
                w_lock_cnt_nxt = 8'd0;
                if (w_gnt_a && lock_a) begin
                    w_arb_st_nxt   = ST_LOCK_A;
                    w_lock_cnt_nxt = 8'd1;
                end else if (w_gnt_b && lock_b) begin
                    w_arb_st_nxt   = ST_LOCK_B;
                    w_lock_cnt_nxt = 8'd1;
                end
            end
            ST_LOCK_A: begin
                w_lock_cnt_nxt = r_lock_cnt + 8'd1;
                // A forced release hands the next tie to the other port.
                if (w_force) begin
                    w_last_gnt_nxt = SEL_A;
                end
                if (!req_a || (w_gnt_a && !lock_a) || w_force) begin
                    w_arb_st_nxt   = ST_IDLE;
                    w_lock_cnt_nxt = 8'd0;
                end
            end
            ST_LOCK_B: begin
                w_lock_cnt_nxt = r_lock_cnt + 8'd1;
                if (w_force) begin
                    w_last_gnt_nxt = SEL_B;
                end
                if (!req_b || (w_gnt_b && !lock_b) || w_force) begin
                    w_arb_st_nxt   = ST_IDLE;
                    w_lock_cnt_nxt = 8'd0;
                end
            end
            default: begin
                w_arb_st_nxt   = ST_IDLE;
                w_lock_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_arb_st   <= ST_IDLE;
            r_last_gnt <= SEL_B;
            r_lock_cnt <= 8'd0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
        end else begin
            r_arb_st   <= w_arb_st_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_rvalid_a <= w_gnt_a && !we_a;
            r_rvalid_b <= w_gnt_b && !we_b;
            if (w_gnt_a && !we_a) begin
                r_rdata_a <= mem_dat_out;
            end
            if (w_gnt_b && !we_b) begin
                r_rdata_b <= mem_dat_out;
            end
        end
    end

    assign gnt_a      = w_gnt_a;
    assign gnt_b      = w_gnt_b;
    assign rvalid_a   = r_rvalid_a;
    assign rvalid_b   = r_rvalid_b;
    assign rdata_a    = r_rdata_a;
    assign rdata_b    = r_rdata_b;

    assign mem_addr   = w_gnt_b ? addr_b  : addr_a;
    assign mem_dat_in = w_gnt_b ? wdata_b : wdata_a;
    assign mem_wr_en  = (w_gnt_a && we_a)  || (w_gnt_b && we_b);
    assign mem_rd_en  = (w_gnt_a && !we_a) || (w_gnt_b && !we_b);

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Directed bench for dat_mem_arbiter: vector table plus burst, lock and reset sequences.
// The memory model preloads mem[a] = a ^ 8'hA5 until a location is written.
module tb_dat_mem_arbiter;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, we_a, lock_a, req_b, we_b, lock_b;
    logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
    logic       mem_wr_en, mem_rd_en;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dat_mem_arbiter #(.LOCK_MAX(16), .AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .mem_addr(mem_addr), .mem_dat_in(mem_dat_in), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_dat_out(mem_dat_out)
    );

    // 256x8 memory: combinational read, clocked write
    bit [7:0] mem_q [256];
    bit       mem_v [256];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem_q[mem_addr] <= mem_dat_in;
            mem_v[mem_addr] <= 1'b1;
        end
    end

    assign mem_dat_out = mem_v[mem_addr] ? mem_q[mem_addr] : (mem_addr ^ 8'hA5);

    function automatic logic [7:0] peek(input logic [7:0] a);
        return mem_v[a] ? mem_q[a] : (a ^ 8'hA5);
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic set_a(input logic r, input logic w, input logic l,
                         input logic [7:0] a, input logic [7:0] d);
        req_a = r; we_a = w; lock_a = l; addr_a = a; wdata_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic l,
                         input logic [7:0] a, input logic [7:0] d);
        req_b = r; we_b = w; lock_b = l; addr_b = a; wdata_b = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_gnt(input string name, input logic ea, input logic eb);
        check1({name, " gnt_a"}, gnt_a, ea);
        check1({name, " gnt_b"}, gnt_b, eb);
    endtask

    typedef struct {
        logic       ra, wa, la;
        logic [7:0] aa, da;
        logic       rb, wb, lb;
        logic [7:0] ab, db;
        logic       eg_a, eg_b, e_wr, e_rd;
        logic [7:0] e_addr;
        logic       ev_a;
        logic [7:0] ed_a;
        logic       ev_b;
        logic [7:0] ed_b;
    } vec_t;

    vec_t vecs [15];
    logic [7:0] bdat [4];

    initial begin
        // ---- vector table: tie reads, write/read-back, single-port streaming ----
        vecs[0] = '{H,L,L,8'h10,8'h00, H,L,L,8'h20,8'h00, H,L,L,H,8'h10, H,8'hB5, L,8'h00};
        vecs[1] = '{H,L,L,8'h10,8'h00, H,L,L,8'h20,8'h00, L,H,L,H,8'h20, L,8'hB5, H,8'h85};
        vecs[2] = '{H,L,L,8'h10,8'h00, H,L,L,8'h20,8'h00, H,L,L,H,8'h10, H,8'hB5, L,8'h85};
        vecs[3] = '{H,L,L,8'h10,8'h00, H,L,L,8'h20,8'h00, L,H,L,H,8'h20, L,8'hB5, H,8'h85};
        vecs[4] = '{H,H,L,8'h33,8'h5A, L,L,L,8'h00,8'h00, H,L,H,L,8'h33, L,8'hB5, L,8'h85};
        vecs[5] = '{H,L,L,8'h33,8'h00, L,L,L,8'h00,8'h00, H,L,L,H,8'h33, H,8'h5A, L,8'h85};
        vecs[6] = '{L,L,L,8'h00,8'h00, L,L,L,8'h00,8'h00, L,L,L,L,8'h00, L,8'h5A, L,8'h85};
        vecs[7]  = '{H,L,L,8'h00,8'h00, L,L,L,8'h00,8'h00, H,L,L,H,8'h00, H,8'hA5, L,8'h85};
        vecs[8]  = '{H,L,L,8'h01,8'h00, L,L,L,8'h00,8'h00, H,L,L,H,8'h01, H,8'hA4, L,8'h85};
        vecs[9]  = '{H,L,L,8'h02,8'h00, L,L,L,8'h00,8'h00, H,L,L,H,8'h02, H,8'hA7, L,8'h85};
        vecs[10] = '{H,L,L,8'h03,8'h00, L,L,L,8'h00,8'h00, H,L,L,H,8'h03, H,8'hA6, L,8'h85};
        vecs[11] = '{H,L,L,8'h04,8'h00, L,L,L,8'h00,8'h00, H,L,L,H,8'h04, H,8'hA1, L,8'h85};
        vecs[12] = '{H,L,L,8'h05,8'h00, L,L,L,8'h00,8'h00, H,L,L,H,8'h05, H,8'hA0, L,8'h85};
        vecs[13] = '{H,L,L,8'h06,8'h00, L,L,L,8'h00,8'h00, H,L,L,H,8'h06, H,8'hA3, L,8'h85};
        vecs[14] = '{H,L,L,8'h07,8'h00, L,L,L,8'h00,8'h00, H,L,L,H,8'h07, H,8'hA2, L,8'h85};
        bdat = '{8'h11, 8'h22, 8'h33, 8'h44};

        // ---- reset with both ports requesting, A attempting a write to 0x05 ----
        reset = 1'b1;
        set_a(H, H, L, 8'h05, 8'hEE);
        set_b(H, L, L, 8'h20, 8'h00);
        for (int r = 0; r < 2; r++) begin
            #1;
            check_gnt($sformatf("rst%0d", r), L, L);
            check1($sformatf("rst%0d wr_en", r), mem_wr_en, L);
            check1($sformatf("rst%0d rd_en", r), mem_rd_en, L);
            tick();
            check1($sformatf("rst%0d rvalid_a", r), rvalid_a, L);
            check1($sformatf("rst%0d rvalid_b", r), rvalid_b, L);
            check8($sformatf("rst%0d rdata_a", r), rdata_a, 8'h00);
            check8($sformatf("rst%0d rdata_b", r), rdata_b, 8'h00);
        end
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            set_a(vecs[i].ra, vecs[i].wa, vecs[i].la, vecs[i].aa, vecs[i].da);
            set_b(vecs[i].rb, vecs[i].wb, vecs[i].lb, vecs[i].ab, vecs[i].db);
            #1;
            check_gnt($sformatf("v%0d", i), vecs[i].eg_a, vecs[i].eg_b);
            check1($sformatf("v%0d wr_en", i), mem_wr_en, vecs[i].e_wr);
            check1($sformatf("v%0d rd_en", i), mem_rd_en, vecs[i].e_rd);
            check8($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            tick();
            check1($sformatf("v%0d rvalid_a", i), rvalid_a, vecs[i].ev_a);
            check8($sformatf("v%0d rdata_a", i), rdata_a, vecs[i].ed_a);
            check1($sformatf("v%0d rvalid_b", i), rvalid_b, vecs[i].ev_b);
            check8($sformatf("v%0d rdata_b", i), rdata_b, vecs[i].ed_b);
        end
        check8("mem 0x33", peek(8'h33), 8'h5A);

        // ---- B locked 4-word write burst while A waits (last grant was A) ----
        set_a(H, L, L, 8'h50, 8'h00);
        for (int k = 0; k < 4; k++) begin
            set_b(H, H, (k < 3), 8'h40 + 8'(k), bdat[k]);
            #1;
            check_gnt($sformatf("burst%0d", k), L, H);
            check1($sformatf("burst%0d wr_en", k), mem_wr_en, H);
            check8($sformatf("burst%0d din", k), mem_dat_in, bdat[k]);
            tick();
            check1($sformatf("burst%0d rvalid_a", k), rvalid_a, L);
        end
        set_b(L, L, L, 8'h00, 8'h00);
        #1;
        check_gnt("burst_end", H, L);
        tick();
        check1("burst_end rvalid_a", rvalid_a, H);
        check8("burst_end rdata_a", rdata_a, 8'hF5);
        for (int k = 0; k < 4; k++) begin
            check8($sformatf("burst mem 0x%02h", 8'h40 + 8'(k)), peek(8'h40 + 8'(k)), bdat[k]);
        end

        // ---- B holds lock: forced release after 16 locked cycles, then alternation ----
        set_a(H, L, L, 8'h61, 8'h00);
        for (int c = 0; c < 22; c++) begin
            set_b(H, L, (c <= 17), 8'h60, 8'h00);
            #1;
            check_gnt($sformatf("force c%0d", c), !((c <= 16) || c == 18 || c == 20),
                      (c <= 16) || c == 18 || c == 20);
            tick();
            if (c == 0) check8("force rdata_b", rdata_b, 8'hC5);
            if (c == 17) begin
                check1("force rvalid_a", rvalid_a, H);
                check8("force rdata_a", rdata_a, 8'hC4);
            end
        end

        // ---- lock release when the owner drops req: other port blocked that cycle ----
        set_a(H, L, H, 8'h70, 8'h00);
        set_b(L, L, L, 8'h00, 8'h00);
        #1;
        check_gnt("rel c0", H, L);
        tick();
        set_a(L, L, L, 8'h00, 8'h00);
        set_b(H, L, L, 8'h71, 8'h00);
        #1;
        check_gnt("rel c1", L, L);
        check1("rel c1 rd_en", mem_rd_en, L);
        tick();
        #1;
        check_gnt("rel c2", L, H);
        tick();
        check1("rel c2 rvalid_b", rvalid_b, H);
        check8("rel c2 rdata_b", rdata_b, 8'hD4);

        // ---- reset in the middle of a locked B burst ----
        set_b(H, H, H, 8'h80, 8'hC1);
        #1;
        check_gnt("rstlk c0", L, H);
        tick();
        set_b(H, L, H, 8'h81, 8'h00);
        #1;
        check_gnt("rstlk c1", L, H);
        tick();
        check8("rstlk c1 rdata_b", rdata_b, 8'h24);
        reset = 1'b1;
        set_a(H, L, L, 8'h90, 8'h00);
        set_b(H, H, H, 8'h82, 8'hC3);
        #1;
        check_gnt("rstlk c2", L, L);
        check1("rstlk c2 wr_en", mem_wr_en, L);
        tick();
        check1("rstlk c2 rvalid_a", rvalid_a, L);
        check1("rstlk c2 rvalid_b", rvalid_b, L);
        check8("rstlk c2 rdata_a", rdata_a, 8'h00);
        check8("rstlk c2 rdata_b", rdata_b, 8'h00);
        check8("rstlk mem 0x82", peek(8'h82), 8'h27);
        reset = 1'b0;
        set_b(H, H, H, 8'h83, 8'hC4);
        #1;
        check_gnt("rstlk c3", H, L);
        tick();
        check1("rstlk c3 rvalid_a", rvalid_a, H);
        check8("rstlk c3 rdata_a", rdata_a, 8'h35);
        set_a(L, L, L, 8'h00, 8'h00);
        set_b(H, H, L, 8'h83, 8'hC4);
        #1;
        check_gnt("rstlk c4", L, H);
        tick();
        set_b(L, L, L, 8'h00, 8'h00);
        check8("rstlk mem 0x80", peek(8'h80), 8'hC1);
        check8("rstlk mem 0x83", peek(8'h83), 8'hC4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
